clock_reset_manager: RTL and testbench
======================================

CLOCK_RESET_MANAGER -- requirements
Module: clock_reset_manager

Interface
REQ-001 Parameter NUM_CH, default 2: number of clock-enable channels, 1..8.
REQ-002 Parameter DIV_WIDTH, default 8: width of each channel divide value.
REQ-003 Parameter LOCK_CYCLES, default 16: consecutive synchronised-lock cycles required before release; value 1 or more.
REQ-004 Parameter RST_HOLD, default 8: cycles sys_resetn is held low after lock is qualified; value 1 or more.
REQ-005 Parameter DIV_INIT, default 0: reset value of every channel divide value.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock (PLL output domain)
- resetn  in  1  asynchronous active-low reset
REQ-007 The remaining ports SHALL be:
- pll_locked  in  1  PLL lock flag, asynchronous to clk
- cfg_we  in  1  divide-value write strobe
- cfg_ch  in  3  target channel of the write
- cfg_div  in  DIV_WIDTH  new divide value
- lost_clr  in  1  clears lock_lost
- sys_resetn  out  1  registered, sequenced system reset, active-low
- clk_en  out  NUM_CH  per-channel one-cycle enable pulses
- lock_lost  out  1  sticky flag: lock dropped while in RUN
- state  out  2  FSM state (0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN)

Function
REQ-008 pll_locked SHALL pass through a 2-flop synchroniser; lock_s is the second flop output, and all FSM decisions use only lock_s.
REQ-009 In WAIT_LOCK, lock_s=1 SHALL move the FSM to STABLE with the stable counter at 1.
REQ-010 In STABLE, the counter SHALL increment while lock_s=1; on reaching LOCK_CYCLES the FSM SHALL enter HOLD with the hold counter at 0.
REQ-011 In HOLD, the hold counter SHALL increment each cycle; after RST_HOLD cycles in HOLD the FSM SHALL enter RUN.
REQ-012 With pll_locked held high, sys_resetn SHALL rise exactly 2+LOCK_CYCLES+RST_HOLD clk edges after the first edge that samples pll_locked=1.
REQ-013 sys_resetn SHALL be 1 only in RUN, and SHALL be a registered output.
REQ-014 lock_s=0 in STABLE, HOLD or RUN SHALL return the FSM to WAIT_LOCK on the next edge and clear all counters.
REQ-015 sys_resetn SHALL fall on the 3rd clk edge after pll_locked falls.
REQ-016 lock_lost SHALL be set only on a RUN-to-WAIT_LOCK transition.
REQ-017 lock_lost SHALL stay set until a cycle with lost_clr=1; if set and clear coincide, set SHALL win.
REQ-018 Each channel i SHALL hold an active divide value div_a[i], a shadow value div_s[i], a pending bit and a counter cnt[i].
REQ-019 clk_en[i] SHALL equal 1 exactly when state=RUN and cnt[i]=div_a[i].
REQ-020 In RUN, cnt[i] SHALL increment each cycle and return to 0 on the cycle clk_en[i]=1, giving period div_a[i]+1; div_a=0 gives clk_en[i] constantly 1.
REQ-021 Outside RUN, every cnt[i] SHALL be held at 0, so the first pulse after release occurs on RUN cycle div_a[i] (counted from 0).
REQ-022 In RUN, cfg_we=1 SHALL load cfg_div into div_s[cfg_ch] and set its pending bit.
REQ-023 On the next clk_en pulse of that channel, div_a SHALL take div_s and pending SHALL clear, so no pulse is shortened or lengthened mid-period.
REQ-024 Outside RUN, cfg_we SHALL load div_a and div_s directly.
REQ-025 cfg_we with cfg_ch >= NUM_CH SHALL be ignored.
REQ-026 A write on the same cycle as a wrap SHALL be applied at the following wrap.
REQ-027 A second write before a wrap SHALL overwrite div_s; the last write wins.
REQ-028 Counter widths SHALL be ceil(log2(max+1)) of the relevant parameter; counters SHALL never wrap past their terminal value.

Reset
REQ-029 While resetn=0, the following SHALL hold:
- state = WAIT_LOCK
- sys_resetn = 0, clk_en = 0, lock_lost = 0
- synchroniser flops, all counters and pending bits = 0
- div_a and div_s = DIV_INIT
REQ-030 Reset assertion SHALL act asynchronously; deassertion SHALL take effect at the next clk edge.
REQ-031 resetn asserted mid-RUN SHALL drop sys_resetn immediately, without waiting for a clk edge.
REQ-032 After resetn is released, the full lock sequence SHALL repeat even if pll_locked never fell.

Verification
REQ-033 LOCK_CYCLES=4, RST_HOLD=2, pll_locked rises at edge 0 -> sys_resetn=1 from edge 8; state passes 0,1,2,3.
REQ-034 pll_locked pulses high for 3 cycles then low (LOCK_CYCLES=4) -> FSM returns to WAIT_LOCK; sys_resetn stays 0.
REQ-035 In RUN, pll_locked falls -> sys_resetn=0 at the 3rd edge, lock_lost=1, clk_en=0; lost_clr pulse -> lock_lost=0.
REQ-036 div_a[0]=3 in RUN -> clk_en[0] pulses every 4 cycles; write cfg_div=1 mid-period -> current 4-cycle period completes, then pulses every 2 cycles.
REQ-037 DIV_INIT=0 -> clk_en[0] is high on every RUN cycle; cfg_ch=7 with NUM_CH=2 -> no channel changes.
REQ-038 resetn pulsed low mid-RUN -> all outputs return to their reset values asynchronously; the full lock sequence then repeats.

Source files
------------

// File: rtl/clock_reset_manager.sv
// Sequences the system reset after PLL lock is qualified and produces
// per-channel clock-enable pulses with glitch-free divide-value updates.
module clock_reset_manager #(
   parameter int NUM_CH      = 2,
   parameter int DIV_WIDTH   = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int RST_HOLD    = 8,
   parameter int DIV_INIT    = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 pll_locked,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_ch,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic                 lost_clr,
   output logic                 sys_resetn,
   output logic [NUM_CH-1:0]    clk_en,
   output logic                 lock_lost,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int STAB_W = $clog2(LOCK_CYCLES + 1);
   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_INIT);

   state_t            cur_state, nxt_state;
   logic              lock_meta, lock_s;
   logic [STAB_W-1:0] stab_cnt, stab_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              in_run;
   logic              lost_set;

   // pll_locked is asynchronous to clk; only lock_s may steer the FSM.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur_state  <= WAIT_LOCK;
         stab_cnt   <= '0;
         hold_cnt   <= '0;
         sys_resetn <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         cur_state  <= nxt_state;
         stab_cnt   <= stab_nxt;
         hold_cnt   <= hold_nxt;
         sys_resetn <= (nxt_state == RUN);
         if (lost_set)
            lock_lost <= 1'b1;
         else if (lost_clr)
            lock_lost <= 1'b0;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a value unassigned (no latch).
   always_comb begin
      nxt_state = cur_state;
      stab_nxt  = '0;
      hold_nxt  = '0;
      case (cur_state)
         WAIT_LOCK: begin
            if (lock_s) begin
               nxt_state = STABLE;
               stab_nxt  = STAB_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s)
               nxt_state = WAIT_LOCK;
            else if (stab_cnt == STAB_W'(LOCK_CYCLES))
               nxt_state = HOLD;
            else
               stab_nxt = stab_cnt + STAB_W'(1);
         end
         HOLD: begin
            if (!lock_s)
               nxt_state = WAIT_LOCK;
            else if (hold_cnt == HOLD_W'(RST_HOLD - 1))
               nxt_state = RUN;
            else
               hold_nxt = hold_cnt + HOLD_W'(1);
         end
         RUN: begin
            if (!lock_s)
               nxt_state = WAIT_LOCK;
         end
         default: nxt_state = WAIT_LOCK;
      endcase
   end

   assign in_run   = (cur_state == RUN);
   assign lost_set = in_run && (nxt_state == WAIT_LOCK);
   assign state    = cur_state;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_a, div_s, cnt;
      logic                 pend, wrap, hit;

      // Channel numbers at or above NUM_CH never match any instance.
      assign hit       = cfg_we && (cfg_ch == 3'(i));
      assign wrap      = in_run && (cnt == div_a);
      assign clk_en[i] = wrap;

      // NOTE: the divide registers are few and software-visible, so they
      // take a defined reset value rather than being left unreset.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            div_a <= DIV_RST;
            div_s <= DIV_RST;
            pend  <= 1'b0;
            cnt   <= '0;
         end else if (!in_run) begin
            cnt <= '0;
            if (hit) begin
               div_a <= cfg_div;
               div_s <= cfg_div;
               pend  <= 1'b0;
            end
         end else begin
            cnt <= wrap ? '0 : cnt + DIV_WIDTH'(1);
            // Shadow moves to active only at a period boundary; a write
            // landing on that same edge waits for the following one.
            if (wrap && pend) begin
               div_a <= div_s;
               pend  <= 1'b0;
            end
            if (hit) begin
               div_s <= cfg_div;
               pend  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_reset_manager.sv
// Self-checking bench for clock_reset_manager: expected output vectors are
// queued as stimulus is applied and compared after each clock edge.
module tb_clock_reset_manager;

   localparam int L   = 4;
   localparam int H   = 2;
   localparam int NCH = 2;
   localparam int DW  = 8;

   logic           clk = 1'b0;
   logic           resetn = 1'b1;
   logic           pll_locked = 1'b0;
   logic           cfg_we = 1'b0;
   logic [2:0]     cfg_ch = 3'd0;
   logic [DW-1:0]  cfg_div = '0;
   logic           lost_clr = 1'b0;
   logic           sys_resetn;
   logic [NCH-1:0] clk_en;
   logic           lock_lost;
   logic [1:0]     state;
   logic [5:0]     obs;

   always #5 clk = ~clk;

   clock_reset_manager #(
      .NUM_CH(NCH), .DIV_WIDTH(DW), .LOCK_CYCLES(L), .RST_HOLD(H), .DIV_INIT(0)
   ) dut (
      .clk(clk), .resetn(resetn), .pll_locked(pll_locked), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .lost_clr(lost_clr),
      .sys_resetn(sys_resetn), .clk_en(clk_en), .lock_lost(lock_lost), .state(state)
   );

   // Observation vector: {state, sys_resetn, lock_lost, clk_en[1:0]}
   assign obs = {state, sys_resetn, lock_lost, clk_en};

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string      tag;
      int         k;
      logic [5:0] exp;
   } sb_t;

   sb_t sb[$];
   sb_t e;

   function automatic logic [5:0] ev(input logic [1:0] s, input logic lost, input logic [1:0] en);
      return {s, (s == 2'd3), lost, en};
   endfunction

   // State after edge k, counted from the first edge sampling pll_locked=1.
   function automatic logic [1:0] seq_state(input int k);
      if (k < 2)         return 2'd0;
      if (k < 2 + L)     return 2'd1;
      if (k < 2 + L + H) return 2'd2;
      return 2'd3;
   endfunction

   // Channel 0 pulse schedule for the divider scenario, in RUN cycles.
   function automatic logic div_pulse(input int r);
      return (r == 3) || (r == 7) || (r == 9) || (r == 11) || (r == 13) ||
             (r == 15) || (r >= 16);
   endfunction

   task automatic push(input string tag, input int k, input logic [5:0] exp);
      sb_t t;
      t.tag = tag;
      t.k   = k;
      t.exp = exp;
      sb.push_back(t);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      #3;
      push("reset_async", 0, ev(2'd0, 1'b0, 2'b00));
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      for (int k = 1; k <= 2; k++) begin
         push("reset_held", k, ev(2'd0, 1'b0, 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k <= 1; k++) begin
         push("reset_release", k, ev(2'd0, 1'b0, 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
   endtask

   task automatic test_lock_seq(input string tag, input logic [1:0] en_run);
      logic [1:0] s;
      pll_locked = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         s = seq_state(k);
         push(tag, k, ev(s, 1'b0, (s == 2'd3) ? en_run : 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
   endtask

   task automatic test_lost;
      pll_locked = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         push("lost_drop", k, ev((k < 2) ? 2'd3 : 2'd0, k >= 2, (k < 2) ? 2'b11 : 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
      lost_clr = 1'b1;
      push("lost_clr", 0, ev(2'd0, 1'b0, 2'b00));
      tick();
      lost_clr = 1'b0;
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      test_lock_seq("relock", 2'b11);
      // Drop lock with lost_clr held: the set must win on the transition edge.
      pll_locked = 1'b0;
      lost_clr   = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         push("lost_set_wins", k, ev((k < 2) ? 2'd3 : 2'd0, k == 2, (k < 2) ? 2'b11 : 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
      lost_clr = 1'b0;
   endtask

   task automatic test_short_pulse;
      for (int k = 0; k <= 8; k++) begin
         pll_locked = (k < 3);
         push("short_pulse", k, ev((k >= 2 && k <= 4) ? 2'd1 : 2'd0, 1'b0, 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
      pll_locked = 1'b0;
   endtask

   task automatic test_divider;
      logic [1:0] s;
      int         r;
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
      push("div_direct", 0, ev(2'd0, 1'b0, 2'b00));
      tick();
      cfg_we = 1'b0;
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      pll_locked = 1'b1;
      for (int k = 0; k <= 28; k++) begin
         r = k - 8;
         cfg_we = 1'b0;
         case (k)
            11: begin cfg_we = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd5; end
            13: begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2; end
            14: begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd1; end
            22: begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd0; end
            default: ;
         endcase
         s = seq_state(k);
         push("divider", k, ev(s, 1'b0, (s == 2'd3) ? {1'b1, div_pulse(r)} : 2'b00));
         tick();
         e = sb.pop_front(); vectors++;
         if (obs !== e.exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
         end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_async_reset;
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
      push("async_pre", 0, ev(2'd3, 1'b0, 2'b11));
      tick();
      cfg_we = 1'b0;
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      push("async_pre", 1, ev(2'd3, 1'b0, 2'b10));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      #3;
      resetn = 1'b0;
      #1;
      push("async_assert", 0, ev(2'd0, 1'b0, 2'b00));
      e = sb.pop_front(); vectors++;
      if (obs !== e.exp) begin
         miscompares++;
         $display("FAIL %s k=%0d got=%b want=%b", e.tag, e.k, obs, e.exp);
      end
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      // pll_locked never fell; the whole sequence must run again with DIV_INIT.
      test_lock_seq("async_relock", 2'b11);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lock_seq("lock_seq", 2'b11);
      test_lost();
      test_short_pulse();
      test_divider();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
